// File: rtl/uart_receiver_65bit_pkg.sv
// Shared constants, state encoding and helpers for the 65-bit UART receiver.
package uart_receiver_65bit_pkg;

  localparam int unsigned FRAME_BITS  = 65;
  localparam int unsigned FRAME_BYTES = 9;
  localparam int unsigned SHADOW_BITS = 64;
  localparam int unsigned CNT_W       = 16;
  localparam int unsigned BIT_IDX_W   = 3;
  localparam int unsigned BYTE_CNT_W  = 4;
  localparam int unsigned TMO_W       = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_t;

  // The last byte carries only frame bit 64; its upper seven bits must be zero.
  function automatic logic pad_ok(input logic [7:0] b);
    return (b[7:1] == 7'd0);
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: input synchroniser plus START/DATA/STOP sampling FSM.
module uart_rx_byte
  import uart_receiver_65bit_pkg::*;
#(
  parameter int unsigned BAUD_DIVISOR = 5208
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_rx,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  output logic       o_byte_ferr,
  output logic       o_active_c
);

  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(BAUD_DIVISOR / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(BAUD_DIVISOR - 1);

  logic                 r_sync1;
  logic                 r_sync2;
  logic                 r_prev;
  rx_state_t            r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [BIT_IDX_W-1:0] r_bit_idx;
  logic [7:0]           r_shift;
  logic [7:0]           r_byte;
  logic                 r_byte_valid;
  logic                 r_byte_ferr;

  // Two-flop synchroniser plus one delayed copy for falling-edge detection; idle-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= i_rx;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // Byte FSM; the baud counter restarts from zero on every state change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_byte       <= '0;
      r_byte_valid <= 1'b0;
      r_byte_ferr  <= 1'b0;
    end else begin
      r_byte_valid <= 1'b0;
      r_byte_ferr  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_cnt     <= '0;
          r_bit_idx <= '0;
          // Needs a genuine 1->0 edge, so a line stuck low after a bad stop bit stays ignored.
          if (r_prev && !r_sync2) begin
            r_state <= ST_START;
          end
        end
        ST_START: begin
          if (r_cnt == HALF_M1) begin
            r_cnt   <= '0;
            r_state <= r_sync2 ? ST_IDLE : ST_DATA;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_DATA: begin
          if (r_cnt == FULL_M1) begin
            r_cnt              <= '0;
            r_shift[r_bit_idx] <= r_sync2;
            r_bit_idx          <= r_bit_idx + BIT_IDX_W'(1);
            if (r_bit_idx == BIT_IDX_W'(7)) begin
              r_state <= ST_STOP;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_STOP: begin
          if (r_cnt == FULL_M1) begin
            r_cnt   <= '0;
            r_state <= ST_IDLE;
            if (r_sync2) begin
              r_byte       <= r_shift;
              r_byte_valid <= 1'b1;
            end else begin
              r_byte_ferr <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign o_byte       = r_byte;
  assign o_byte_valid = r_byte_valid;
  assign o_byte_ferr  = r_byte_ferr;
  assign o_active_c   = (r_state != ST_IDLE);

endmodule

// File: rtl/uart_receiver_65bit.sv
// 65-bit frame receiver: assembles nine 8N1 bytes into one frame with strobes.
module uart_receiver_65bit
  import uart_receiver_65bit_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ   = 50_000_000,
  parameter int unsigned BAUD_RATE    = 9600,
  parameter int unsigned TIMEOUT_BITS = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_input_uart,
  output logic [FRAME_BITS-1:0] rx_frame_data,
  output logic                  rx_frame_valid,
  output logic                  rx_frame_error,
  output logic                  rx_busy
);

  localparam int unsigned BAUD_DIVISOR = CLOCK_FREQ / BAUD_RATE;
  localparam int unsigned TMO_LIMIT_M1 = TIMEOUT_BITS * BAUD_DIVISOR - 1;

  logic [7:0]             w_byte;
  logic                   w_byte_valid;
  logic                   w_byte_ferr;
  logic                   w_active;

  logic [BYTE_CNT_W-1:0]  r_byte_cnt;
  logic [SHADOW_BITS-1:0] r_shadow;
  logic [TMO_W-1:0]       r_tmo_cnt;
  logic [FRAME_BITS-1:0]  r_frame_data;
  logic                   r_frame_valid;
  logic                   r_frame_error;
  logic                   r_busy;

  uart_rx_byte #(
    .BAUD_DIVISOR (BAUD_DIVISOR)
  ) u_rx_byte (
    .clk          (clk),
    .rst          (rst),
    .i_rx         (rx_input_uart),
    .o_byte       (w_byte),
    .o_byte_valid (w_byte_valid),
    .o_byte_ferr  (w_byte_ferr),
    .o_active_c   (w_active)
  );

  // Frame assembly, pad check, inter-byte timeout and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_byte_cnt    <= '0;
      r_shadow      <= '0;
      r_tmo_cnt     <= '0;
      r_frame_data  <= '0;
      r_frame_valid <= 1'b0;
      r_frame_error <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_frame_valid <= 1'b0;
      r_frame_error <= 1'b0;
      r_busy        <= w_active | (r_byte_cnt != '0);

      // Timeout only runs while idle with a partial frame; a start edge leaves IDLE and clears it.
      if (w_active || (r_byte_cnt == '0)) begin
        r_tmo_cnt <= '0;
      end else if (r_tmo_cnt == TMO_W'(TMO_LIMIT_M1)) begin
        r_tmo_cnt     <= '0;
        r_frame_error <= 1'b1;
        r_byte_cnt    <= '0;
      end else begin
        r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
      end

      if (w_byte_ferr) begin
        r_frame_error <= 1'b1;
        r_byte_cnt    <= '0;
      end else if (w_byte_valid) begin
        if (r_byte_cnt == BYTE_CNT_W'(FRAME_BYTES - 1)) begin
          r_byte_cnt <= '0;
          if (pad_ok(w_byte)) begin
            r_frame_data  <= {w_byte[0], r_shadow};
            r_frame_valid <= 1'b1;
          end else begin
            r_frame_error <= 1'b1;
          end
        end else begin
          r_shadow[{r_byte_cnt[2:0], 3'b000} +: 8] <= w_byte;
          r_byte_cnt <= r_byte_cnt + BYTE_CNT_W'(1);
        end
      end
    end
  end

  assign rx_frame_data  = r_frame_data;
  assign rx_frame_valid = r_frame_valid;
  assign rx_frame_error = r_frame_error;
  assign rx_busy        = r_busy;

endmodule

// File: tb/tb_uart_receiver_65bit.sv
// Self-checking bench for uart_receiver_65bit with an event-level frame model.
module tb_uart_receiver_65bit;

  localparam int unsigned CLOCK_FREQ   = 320;
  localparam int unsigned BAUD_RATE    = 10;
  localparam int unsigned TIMEOUT_BITS = 20;
  localparam int unsigned DIV          = CLOCK_FREQ / BAUD_RATE;

  typedef logic [7:0] fb_t [9];
  typedef struct {
    bit          is_err;
    logic [64:0] data;
  } ev_t;

  logic        clk;
  logic        rst;
  logic        rx;
  logic [64:0] rx_frame_data;
  logic        rx_frame_valid;
  logic        rx_frame_error;
  logic        rx_busy;

  ev_t         exp_q[$];
  logic [7:0]  m_bytes[$];
  logic [64:0] m_last;
  int          n_checks;
  int          n_fail;

  uart_receiver_65bit #(
    .CLOCK_FREQ   (CLOCK_FREQ),
    .BAUD_RATE    (BAUD_RATE),
    .TIMEOUT_BITS (TIMEOUT_BITS)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rx_input_uart  (rx),
    .rx_frame_data  (rx_frame_data),
    .rx_frame_valid (rx_frame_valid),
    .rx_frame_error (rx_frame_error),
    .rx_busy        (rx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic fb_t frame_to_bytes(input logic [64:0] f);
    fb_t b;
    for (int k = 0; k < 8; k++) b[k] = f[8*k +: 8];
    b[8] = {7'd0, f[64]};
    return b;
  endfunction

  // Model: what one received byte does to the frame being assembled.
  task automatic model_byte(input logic [7:0] b, input bit stop_ok);
    logic [64:0] f;
    if (!stop_ok) begin
      exp_q.push_back('{is_err: 1'b1, data: 65'd0});
      m_bytes.delete();
      return;
    end
    m_bytes.push_back(b);
    if (m_bytes.size() == 9) begin
      if (b[7:1] != 7'd0) begin
        exp_q.push_back('{is_err: 1'b1, data: 65'd0});
      end else begin
        for (int k = 0; k < 8; k++) f[8*k +: 8] = m_bytes[k];
        f[64] = b[0];
        exp_q.push_back('{is_err: 1'b0, data: f});
      end
      m_bytes.delete();
    end
  endtask

  // Model: a partial frame left idle long enough is dropped with an error.
  task automatic model_timeout();
    if (m_bytes.size() != 0) begin
      exp_q.push_back('{is_err: 1'b1, data: 65'd0});
      m_bytes.delete();
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    model_byte(b, stop_ok);
    rx = 1'b0;
    wait_cycles(DIV);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_cycles(DIV);
    end
    rx = stop_ok;
    wait_cycles(DIV);
    rx = 1'b1;
  endtask

  // Sends a frame's bytes with small random gaps; aborts after a bad stop bit.
  task automatic send_frame(input fb_t bs, input int bad_idx, input int gap_max_bits);
    for (int i = 0; i < 9; i++) begin
      send_byte(bs[i], i != bad_idx);
      if (i == bad_idx) begin
        wait_cycles(2 * DIV);
        return;
      end
      if (gap_max_bits > 0) wait_cycles($urandom_range(gap_max_bits * DIV, 0));
    end
  endtask

  // Event-level comparison on every cycle outside reset.
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_frame_valid && rx_frame_error) chk("valid_and_error", 65'd1, 65'd0);
      if (rx_frame_valid || rx_frame_error) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", {63'd0, rx_frame_valid, rx_frame_error}, 65'd0);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          chk("strobe_kind_err", {64'd0, rx_frame_error}, {64'd0, e.is_err});
          if (!e.is_err) m_last = e.data;
        end
      end
      chk("frame_data", rx_frame_data, m_last);
    end
  end

  initial begin
    fb_t         bs;
    logic [64:0] f;
    n_checks = 0;
    n_fail   = 0;
    m_last   = '0;
    rx       = 1'b1;
    rst      = 1'b1;
    wait_cycles(5);
    chk("reset_data", rx_frame_data, 65'd0);
    chk("reset_valid", {64'd0, rx_frame_valid}, 65'd0);
    chk("reset_error", {64'd0, rx_frame_error}, 65'd0);
    chk("reset_busy", {64'd0, rx_busy}, 65'd0);
    rst = 1'b0;
    wait_cycles(2 * DIV);

    // Known frame, literal expectations.
    send_frame(frame_to_bytes(65'h1_DEAD_BEEF_0123_4567), -1, 0);
    wait_cycles(3 * DIV);
    chk("t1_data_literal", rx_frame_data, 65'h1_DEAD_BEEF_0123_4567);
    chk("t1_all_events", 65'(exp_q.size()), 65'd0);
    chk("t1_busy_idle", {64'd0, rx_busy}, 65'd0);

    // Bad stop bit on byte 2, then a clean all-ones frame.
    send_frame(frame_to_bytes(65'h0_1122_3344_5566_7788), 2, 0);
    wait_cycles(DIV);
    chk("t2_err_seen", 65'(exp_q.size()), 65'd0);
    chk("t2_data_kept", rx_frame_data, 65'h1_DEAD_BEEF_0123_4567);
    send_frame(frame_to_bytes(65'h0_FFFF_FFFF_FFFF_FFFF), -1, 1);
    wait_cycles(3 * DIV);
    chk("t2_data_literal", rx_frame_data, 65'h0_FFFF_FFFF_FFFF_FFFF);

    // Bad pad in byte 8.
    bs    = frame_to_bytes(65'h0_0102_0304_0506_0708);
    bs[8] = 8'h03;
    send_frame(bs, -1, 0);
    wait_cycles(3 * DIV);
    chk("t3_err_seen", 65'(exp_q.size()), 65'd0);
    chk("t3_data_kept", rx_frame_data, 65'h0_FFFF_FFFF_FFFF_FFFF);

    // Partial frame then idle: error near 20 bit periods, not before.
    bs = frame_to_bytes(65'h1_A5A5_5A5A_C3C3_3C3C);
    for (int i = 0; i < 4; i++) send_byte(bs[i], 1'b1);
    chk("t4_busy_partial", {64'd0, rx_busy}, 65'd1);
    model_timeout();
    wait_cycles(18 * DIV);
    chk("t4_tmo_not_early", 65'(exp_q.size()), 65'd1);
    wait_cycles(7 * DIV);
    chk("t4_tmo_fired", 65'(exp_q.size()), 65'd0);
    chk("t4_busy_cleared", {64'd0, rx_busy}, 65'd0);
    send_frame(bs, -1, 2);
    wait_cycles(3 * DIV);
    chk("t4_data_literal", rx_frame_data, 65'h1_A5A5_5A5A_C3C3_3C3C);

    // Short low glitch on an idle line.
    rx = 1'b0;
    wait_cycles(3);
    rx = 1'b1;
    wait_cycles(3 * DIV);
    chk("t5_no_events", 65'(exp_q.size()), 65'd0);
    chk("t5_busy_idle", {64'd0, rx_busy}, 65'd0);
    chk("t5_data_kept", rx_frame_data, 65'h1_A5A5_5A5A_C3C3_3C3C);

    // Asynchronous reset in the middle of byte 5.
    bs = frame_to_bytes(65'h0_CAFE_F00D_1357_9BDF);
    for (int i = 0; i < 5; i++) send_byte(bs[i], 1'b1);
    rx = 1'b0;
    wait_cycles(DIV + 3 * DIV);
    #3;
    rst = 1'b1;
    #1;
    chk("t6_rst_data", rx_frame_data, 65'd0);
    chk("t6_rst_valid", {64'd0, rx_frame_valid}, 65'd0);
    chk("t6_rst_error", {64'd0, rx_frame_error}, 65'd0);
    chk("t6_rst_busy", {64'd0, rx_busy}, 65'd0);
    rx = 1'b1;
    exp_q.delete();
    m_bytes.delete();
    m_last = '0;
    wait_cycles(3);
    rst = 1'b0;
    wait_cycles(2 * DIV);
    chk("t6_busy_after", {64'd0, rx_busy}, 65'd0);
    send_frame(bs, -1, 1);
    wait_cycles(3 * DIV);
    chk("t6_data_literal", rx_frame_data, 65'h0_CAFE_F00D_1357_9BDF);

    // Randomised frames with occasional bad stop bits and bad pads.
    for (int n = 0; n < 12; n++) begin
      f  = {1'($urandom_range(1, 0)), $urandom(), $urandom()};
      bs = frame_to_bytes(f);
      if ($urandom_range(4, 0) == 0) bs[8] = {7'($urandom_range(127, 1)), f[64]};
      send_frame(bs, ($urandom_range(5, 0) == 0) ? int'($urandom_range(8, 0)) : -1, 3);
      wait_cycles($urandom_range(3 * DIV, DIV));
    end
    wait_cycles(2 * DIV);
    chk("final_all_events", 65'(exp_q.size()), 65'd0);
    chk("final_busy_idle", {64'd0, rx_busy}, 65'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
